// File: rtl/ccff_stream_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ccff_stream_loader: serialises bitstream words into a configuration-FF chain
// with shift-enable generation and parity of the displaced chain contents.
// Revision: 1.0
// ----------------------------------------------------------------------------
module ccff_stream_loader #(
   parameter int CHAIN_LEN = 52,
   parameter int DATA_W    = 8
) (
   input  logic              prog_clk,
   input  logic              pReset,
   input  logic              start,
   input  logic              bs_valid,
   input  logic [0:DATA_W-1] bs_data,
   output logic              bs_ready,
   output logic              ccff_head,
   input  logic              ccff_tail,
   output logic              cfg_clk_en,
   output logic              busy,
   output logic              done,
   output logic              tail_parity
);

   localparam int NWORDS    = (CHAIN_LEN + DATA_W - 1) / DATA_W;
   localparam int LAST_BITS = CHAIN_LEN - (NWORDS - 1) * DATA_W;
   localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
   localparam int WCNT_W    = $clog2(NWORDS + 1);
   localparam int IDX_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CHAIN_LEN - 1);
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(NWORDS - 1);
   localparam logic [WCNT_W-1:0] WCNT_MAX  = WCNT_W'(NWORDS);
   localparam logic [IDX_W-1:0]  IDX_FULL  = IDX_W'(DATA_W - 1);
   localparam logic [IDX_W-1:0]  IDX_TRIM  = IDX_W'(LAST_BITS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [CNT_W-1:0]    shift_cnt;
   logic [WCNT_W-1:0]   word_cnt;
   logic [0:DATA_W-1]   sr_data;
   logic                sr_valid;
   logic                sr_final;
   logic [IDX_W-1:0]    sr_idx;
   logic                start_ok;
   logic                shift_en;
   logic                last_bit;
   logic                accept;
   logic                final_shift;

   assign start_ok    = start & (state != LOAD);
   assign shift_en    = (state == LOAD) & sr_valid;
   // The final word stops early so its high-index bits are never shifted.
   assign last_bit    = (sr_idx == (sr_final ? IDX_TRIM : IDX_FULL));
   assign bs_ready    = (state == LOAD) & (word_cnt < WCNT_MAX) & (~sr_valid | last_bit);
   assign accept      = bs_valid & bs_ready;
   assign final_shift = shift_en & (shift_cnt == CNT_LAST);

   assign ccff_head   = sr_valid & sr_data[sr_idx];
   assign cfg_clk_en  = shift_en;
   assign busy        = (state == LOAD);
   assign done        = (state == DONE);

   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            if (final_shift) begin
               state_nxt = DONE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge prog_clk or posedge pReset) begin
      if (pReset) begin
         shift_cnt   <= '0;
         word_cnt    <= '0;
         sr_data     <= '0;
         sr_valid    <= 1'b0;
         sr_final    <= 1'b0;
         sr_idx      <= '0;
         tail_parity <= 1'b0;
      end else if (start_ok) begin
         shift_cnt   <= '0;
         word_cnt    <= '0;
         sr_data     <= '0;
         sr_valid    <= 1'b0;
         sr_final    <= 1'b0;
         sr_idx      <= '0;
         tail_parity <= 1'b0;
      end else if (state == LOAD) begin
         if (shift_en) begin
            shift_cnt   <= shift_cnt + CNT_W'(1);
            tail_parity <= tail_parity ^ ccff_tail;
            if (last_bit) begin
               sr_valid <= 1'b0;
            end else begin
               sr_idx <= sr_idx + IDX_W'(1);
            end
         end
         // A new word overrides the emptying above, giving bubble-free streaming.
         if (accept) begin
            sr_data  <= bs_data;
            sr_valid <= 1'b1;
            sr_idx   <= '0;
            sr_final <= (word_cnt == WCNT_LAST);
            word_cnt <= word_cnt + WCNT_W'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ccff_stream_loader.sv
`default_nettype none
// tb_ccff_stream_loader: random bitstream loads checked against a model of the
// downstream chain and of the expected bit order and tail parity.
module tb_ccff_stream_loader;

   localparam int CL = 52;
   localparam int DW = 8;
   localparam int NW = (CL + DW - 1) / DW;

   logic          prog_clk = 1'b0;
   logic          pReset   = 1'b1;
   logic          start    = 1'b0;
   logic          bs_valid = 1'b0;
   logic [0:DW-1] bs_data  = '0;
   logic          bs_ready, ccff_head, ccff_tail, cfg_clk_en, busy, done, tail_parity;

   logic          s_start = 1'b0;
   logic          s_valid = 1'b0;
   logic [0:7]    s_data  = '0;
   logic          s_ready, s_head, s_tail, s_en, s_busy, s_done, s_par;

   logic [CL-1:0] chain;
   logic          s_chain;
   logic          pre_req   = 1'b0;
   logic [CL-1:0] pre_val   = '0;
   logic          s_pre_val = 1'b0;

   int            total = 0;
   int            bad   = 0;
   logic [0:DW-1] words [NW];
   logic [CL-1:0] old_chain;
   logic [CL-1:0] first_chain;

   always #5 prog_clk = ~prog_clk;

   ccff_stream_loader #(.CHAIN_LEN(CL), .DATA_W(DW)) dut (
      .prog_clk(prog_clk), .pReset(pReset), .start(start),
      .bs_valid(bs_valid), .bs_data(bs_data), .bs_ready(bs_ready),
      .ccff_head(ccff_head), .ccff_tail(ccff_tail), .cfg_clk_en(cfg_clk_en),
      .busy(busy), .done(done), .tail_parity(tail_parity)
   );

   ccff_stream_loader #(.CHAIN_LEN(1), .DATA_W(8)) dut_small (
      .prog_clk(prog_clk), .pReset(pReset), .start(s_start),
      .bs_valid(s_valid), .bs_data(s_data), .bs_ready(s_ready),
      .ccff_head(s_head), .ccff_tail(s_tail), .cfg_clk_en(s_en),
      .busy(s_busy), .done(s_done), .tail_parity(s_par)
   );

   // Downstream chains: new bits enter at the head end, the tail is the oldest.
   always @(posedge prog_clk) begin
      if (pre_req) begin
         chain   <= pre_val;
         s_chain <= s_pre_val;
      end else begin
         if (cfg_clk_en) chain <= {chain[CL-2:0], ccff_head};
         if (s_en) s_chain <= s_head;
      end
   end
   assign ccff_tail = chain[CL-1];
   assign s_tail    = s_chain;

   task automatic preload(input logic [CL-1:0] v, input logic sv);
      @(negedge prog_clk);
      pre_val   = v;
      s_pre_val = sv;
      pre_req   = 1'b1;
      @(negedge prog_clk);
      pre_req   = 1'b0;
   endtask

   function automatic logic [CL-1:0] exp_chain();
      logic [CL-1:0] e;
      for (int k = 0; k < CL; k++) e[CL-1-k] = words[k / DW][k % DW];
      return e;
   endfunction

   function automatic logic [CL-1:0] rand_chain();
      logic [CL-1:0] r;
      for (int i = 0; i < CL; i++) r[i] = 1'($urandom);
      return r;
   endfunction

   task automatic run_load(input bit new_words, input int stall_word, input int stall_n,
                           input bit rnd_valid, input int start_at, input int abort_at,
                           output int shifts, output int gaps, output int xfers,
                           output bit rdy_early, output bit extra_ready,
                           output bit late_done, output bit tmo);
      int k, cyc, first, last, stall_left;
      bit drop;
      if (new_words) for (int i = 0; i < NW; i++) words[i] = DW'($urandom);
      old_chain = chain;
      k = 0; cyc = 0; first = -1; last = -1; shifts = 0; xfers = 0;
      extra_ready = 0; late_done = 0; tmo = 0; stall_left = stall_n;
      @(negedge prog_clk);
      start = 1'b1;
      @(negedge prog_clk);
      start = 1'b0;
      rdy_early = bs_ready & busy;
      while (!done && cyc < 400 && !(abort_at >= 0 && shifts == abort_at)) begin
         drop = 0;
         if (k == stall_word && stall_left > 0 && bs_ready) begin
            drop = 1;
            stall_left--;
         end
         if (rnd_valid && $urandom_range(0, 2) == 0) drop = 1;
         bs_valid = (k < NW) && !drop;
         bs_data  = (k < NW) ? words[k] : DW'($urandom);
         start    = (cyc == start_at);
         #1;
         if (k >= NW && bs_ready) extra_ready = 1;
         if (bs_valid && bs_ready) begin
            k++;
            xfers++;
         end
         if (cfg_clk_en) begin
            shifts++;
            if (first < 0) first = cyc;
            last = cyc;
         end
         @(negedge prog_clk);
         cyc++;
      end
      bs_valid = 1'b0;
      start    = 1'b0;
      if (cyc >= 400) tmo = 1;
      if (done && (cyc - last) != 1) late_done = 1;
      gaps = (first < 0) ? 0 : (last - first + 1 - shifts);
   endtask

   task automatic test_reset();
      #3;
      total++;
      if ({bs_ready, ccff_head, cfg_clk_en, busy, done, tail_parity,
           s_ready, s_head, s_en, s_busy, s_done, s_par} !== 12'b0) begin
         bad++;
         $display("FAIL reset_outputs: got %b want 0", {bs_ready, ccff_head, cfg_clk_en,
                  busy, done, tail_parity, s_ready, s_head, s_en, s_busy, s_done, s_par});
      end
      @(negedge prog_clk);
      pReset = 1'b0;
      repeat (2) @(negedge prog_clk);
      total++;
      if ({busy, done, bs_ready, cfg_clk_en} !== 4'b0) begin
         bad++;
         $display("FAIL idle_after_reset: got %b want 0000", {busy, done, bs_ready, cfg_clk_en});
      end
   endtask

   task automatic test_basic();
      int sh, gp, xf; bit re, er, ld, to;
      preload('0, 1'b0);
      run_load(1, -1, 0, 0, -1, -1, sh, gp, xf, re, er, ld, to);
      total++;
      if (re !== 1'b1) begin bad++; $display("FAIL basic_ready_after_start: got %b want 1", re); end
      total++;
      if (to || sh != CL || gp != 0) begin
         bad++; $display("FAIL basic_shifts: got shifts=%0d gaps=%0d tmo=%0d want %0d/0/0", sh, gp, to, CL);
      end
      total++;
      if (xf != NW || er) begin
         bad++; $display("FAIL basic_xfers: got %0d extra_ready=%0d want %0d/0", xf, er, NW);
      end
      total++;
      if (ld || {done, busy, bs_ready, cfg_clk_en} !== 4'b1000) begin
         bad++; $display("FAIL basic_done: got late=%0d dbrc=%b want 0/1000", ld, {done, busy, bs_ready, cfg_clk_en});
      end
      total++;
      if (tail_parity !== ^old_chain) begin
         bad++; $display("FAIL basic_parity: got %b want %b", tail_parity, ^old_chain);
      end
      total++;
      if (chain !== exp_chain()) begin
         bad++; $display("FAIL basic_chain: got %h want %h", chain, exp_chain());
      end
      first_chain = chain;
   endtask

   task automatic test_stall();
      int sh, gp, xf; bit re, er, ld, to;
      preload('0, 1'b0);
      run_load(0, 3, 3, 0, -1, -1, sh, gp, xf, re, er, ld, to);
      total++;
      if (to || sh != CL || gp != 3) begin
         bad++; $display("FAIL stall_gaps: got shifts=%0d gaps=%0d tmo=%0d want %0d/3/0", sh, gp, to, CL);
      end
      total++;
      if (chain !== first_chain) begin
         bad++; $display("FAIL stall_chain: got %h want %h", chain, first_chain);
      end
   endtask

   task automatic test_parity();
      int sh, gp, xf; bit re, er, ld, to;
      logic [7:0] a5;
      logic [CL-1:0] pat;
      a5 = 8'hA5;
      for (int i = 0; i < CL; i++) pat[CL-1-i] = a5[7 - (i % 8)];
      preload(pat, 1'b0);
      run_load(1, -1, 0, 0, -1, -1, sh, gp, xf, re, er, ld, to);
      total++;
      if (to || tail_parity !== ^pat) begin
         bad++; $display("FAIL parity_a5: got %b want %b", tail_parity, ^pat);
      end
      pat = rand_chain();
      if (^pat == 1'b0) pat[0] = ~pat[0];
      preload(pat, 1'b0);
      run_load(1, -1, 0, 0, -1, -1, sh, gp, xf, re, er, ld, to);
      total++;
      if (to || tail_parity !== 1'b1) begin
         bad++; $display("FAIL parity_odd: got %b want 1", tail_parity);
      end
      total++;
      if (chain !== exp_chain()) begin
         bad++; $display("FAIL parity_chain: got %h want %h", chain, exp_chain());
      end
   endtask

   task automatic test_reset_midload();
      int sh, gp, xf; bit re, er, ld, to;
      preload(rand_chain(), 1'b0);
      run_load(1, -1, 0, 0, -1, 20, sh, gp, xf, re, er, ld, to);
      total++;
      if (sh != 20 || busy !== 1'b1) begin
         bad++; $display("FAIL midload_progress: got shifts=%0d busy=%b want 20/1", sh, busy);
      end
      pReset = 1'b1;
      #1;
      total++;
      if ({bs_ready, ccff_head, cfg_clk_en, busy, done, tail_parity} !== 6'b0) begin
         bad++; $display("FAIL midload_reset_outputs: got %b want 0",
                         {bs_ready, ccff_head, cfg_clk_en, busy, done, tail_parity});
      end
      #2;
      pReset = 1'b0;
      @(negedge prog_clk);
      total++;
      if ({busy, cfg_clk_en, bs_ready} !== 3'b0) begin
         bad++; $display("FAIL midload_needs_start: got %b want 000", {busy, cfg_clk_en, bs_ready});
      end
      run_load(1, -1, 0, 0, -1, -1, sh, gp, xf, re, er, ld, to);
      total++;
      if (to || sh != CL || chain !== exp_chain()) begin
         bad++; $display("FAIL midload_reload: got shifts=%0d chain=%h want %0d/%h", sh, chain, CL, exp_chain());
      end
      total++;
      if (tail_parity !== ^old_chain) begin
         bad++; $display("FAIL midload_parity: got %b want %b", tail_parity, ^old_chain);
      end
   endtask

   task automatic test_start_ignored();
      int sh, gp, xf; bit re, er, ld, to;
      preload(rand_chain(), 1'b0);
      run_load(1, -1, 0, 0, 10, -1, sh, gp, xf, re, er, ld, to);
      total++;
      if (to || sh != CL || gp != 0 || xf != NW) begin
         bad++; $display("FAIL start_ignored_shifts: got shifts=%0d gaps=%0d xfers=%0d want %0d/0/%0d", sh, gp, xf, CL, NW);
      end
      total++;
      if (chain !== exp_chain() || done !== 1'b1) begin
         bad++; $display("FAIL start_ignored_chain: got %h done=%b want %h/1", chain, done, exp_chain());
      end
   endtask

   task automatic test_random_valid();
      int sh, gp, xf; bit re, er, ld, to;
      for (int it = 0; it < 3; it++) begin
         preload(rand_chain(), 1'b0);
         run_load(1, -1, 0, 1, -1, -1, sh, gp, xf, re, er, ld, to);
         total++;
         if (to || sh != CL || xf != NW || er || ld) begin
            bad++; $display("FAIL random_counts: got shifts=%0d xfers=%0d extra=%0d late=%0d tmo=%0d", sh, xf, er, ld, to);
         end
         total++;
         if (chain !== exp_chain() || tail_parity !== ^old_chain) begin
            bad++; $display("FAIL random_result: got %h/%b want %h/%b", chain, tail_parity, exp_chain(), ^old_chain);
         end
      end
   endtask

   task automatic test_single();
      logic [0:7] w;
      logic       old;
      int         acc, sh, cyc;
      for (int it = 0; it < 2; it++) begin
         old = 1'(it);
         w   = 8'($urandom);
         w[0] = ~old;
         preload(chain, old);
         @(negedge prog_clk);
         s_start = 1'b1;
         @(negedge prog_clk);
         s_start = 1'b0;
         acc = 0; sh = 0; cyc = 0;
         while (!s_done && cyc < 50) begin
            s_valid = 1'b1;
            s_data  = w;
            #1;
            if (s_valid && s_ready) acc++;
            if (s_en) sh++;
            @(negedge prog_clk);
            cyc++;
         end
         repeat (3) begin
            #1;
            if (s_ready) acc++;
            if (s_en) sh++;
            @(negedge prog_clk);
         end
         s_valid = 1'b0;
         total++;
         if (acc != 1 || sh != 1 || s_done !== 1'b1) begin
            bad++; $display("FAIL single_counts: got acc=%0d shifts=%0d done=%b want 1/1/1", acc, sh, s_done);
         end
         total++;
         if (s_chain !== w[0] || s_par !== old) begin
            bad++; $display("FAIL single_result: got chain=%b parity=%b want %b/%b", s_chain, s_par, w[0], old);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_parity();
      test_reset_midload();
      test_start_ignored();
      test_random_valid();
      test_single();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
